// File: rtl/rv32_wb_pkg.sv
// Shared types for the multi-lane RV32 writeback/retire stage.
package rv32_wb_pkg;

   localparam int          NRET_MAX    = 4;
   localparam logic [1:0]  RVFI_MODE_M = 2'd3;

   typedef enum logic {RUN, HALTED} wb_state_e;

   typedef struct packed {
      logic        valid;
      logic [63:0] order;
      logic [31:0] insn;
      logic        trap;
      logic        halt;
      logic        intr;
      logic [1:0]  mode;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] rs1_rdata;
      logic [31:0] rs2_rdata;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
      logic [31:0] mem_addr;
      logic [3:0]  mem_rmask;
      logic [3:0]  mem_wmask;
      logic [31:0] mem_rdata;
      logic [31:0] mem_wdata;
   } rvfi_lane_t;

endpackage

// File: rtl/rv32_wb_compact.sv
// Packs live lanes in age order into the low RVFI slots and assigns their order numbers.
module rv32_wb_compact
   import rv32_wb_pkg::*;
#(
   parameter int NRET = 2,
   parameter int CW   = $clog2(NRET + 1)
) (
   input  logic [NRET-1:0]        live,
   input  rvfi_lane_t [NRET-1:0]  lanes_in,
   input  logic [63:0]            order_base,
   output rvfi_lane_t [NRET-1:0]  lanes_out,
   output logic [CW-1:0]          count
);

   int unsigned slot;

   // slot is the running popcount of older live lanes, i.e. each lane's packed position
   always_comb begin
      lanes_out = '0;
      slot      = 0;
      for (int unsigned k = 0; k < NRET; k++) begin
         if (live[k]) begin
            lanes_out[slot]       = lanes_in[k];
            lanes_out[slot].valid = 1'b1;
            lanes_out[slot].order = order_base + 64'(slot);
            slot                  = slot + 1;
         end
      end
      count = CW'(slot);
   end

endmodule

// File: rtl/rv32_writeback_nret.sv
// NRET-lane writeback/retire: RF write conflict resolution, compacted RVFI stream, instret and halt state.
module rv32_writeback_nret
   import rv32_wb_pkg::*;
#(
   parameter int NRET = 2,
   parameter int XLEN = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_in,
   input  logic [NRET-1:0]      valid_in,
   input  logic [NRET-1:0]      trap_in,
   input  logic [NRET-1:0]      halt_in,
   input  logic [NRET-1:0]      intr_in,
   input  logic [NRET*5-1:0]    rd_in,
   input  logic [NRET*5-1:0]    rs1_in,
   input  logic [NRET*5-1:0]    rs2_in,
   input  logic [NRET-1:0]      rd_write_in,
   input  logic [NRET*XLEN-1:0] rd_value_in,
   input  logic [NRET*XLEN-1:0] rs1_value_in,
   input  logic [NRET*XLEN-1:0] rs2_value_in,
   input  logic [NRET*XLEN-1:0] pc_in,
   input  logic [NRET*XLEN-1:0] next_pc_in,
   input  logic [NRET*XLEN-1:0] instr_in,
   input  logic [NRET*XLEN-1:0] mem_address_in,
   input  logic [NRET*XLEN-1:0] mem_read_value_in,
   input  logic [NRET*XLEN-1:0] mem_write_value_in,
   input  logic [NRET*4-1:0]    mem_read_mask_in,
   input  logic [NRET*4-1:0]    mem_write_mask_in,
   output logic [NRET-1:0]      rf_we_out,
   output logic [NRET*5-1:0]    rf_waddr_out,
   output logic [NRET*XLEN-1:0] rf_wdata_out,
   output logic [63:0]          instret_out,
   output logic                 halted_out,
   output logic [NRET-1:0]      rvfi_valid,
   output logic [NRET*64-1:0]   rvfi_order,
   output logic [NRET*32-1:0]   rvfi_insn,
   output logic [NRET-1:0]      rvfi_trap,
   output logic [NRET-1:0]      rvfi_halt,
   output logic [NRET-1:0]      rvfi_intr,
   output logic [NRET*2-1:0]    rvfi_mode,
   output logic [NRET*5-1:0]    rvfi_rs1_addr,
   output logic [NRET*5-1:0]    rvfi_rs2_addr,
   output logic [NRET*32-1:0]   rvfi_rs1_rdata,
   output logic [NRET*32-1:0]   rvfi_rs2_rdata,
   output logic [NRET*5-1:0]    rvfi_rd_addr,
   output logic [NRET*32-1:0]   rvfi_rd_wdata,
   output logic [NRET*32-1:0]   rvfi_pc_rdata,
   output logic [NRET*32-1:0]   rvfi_pc_wdata,
   output logic [NRET*32-1:0]   rvfi_mem_addr,
   output logic [NRET*4-1:0]    rvfi_mem_rmask,
   output logic [NRET*4-1:0]    rvfi_mem_wmask,
   output logic [NRET*32-1:0]   rvfi_mem_rdata,
   output logic [NRET*32-1:0]   rvfi_mem_wdata
);

   localparam int CW = $clog2(NRET + 1);

   wb_state_e             state, state_next;
   logic [NRET-1:0]       live, we_pre;
   logic                  halt_live;
   logic [CW-1:0]         live_cnt, ret_cnt;
   logic [63:0]           order_base, instret;
   rvfi_lane_t [NRET-1:0] lanes, packed_lanes, rvfi_q;

   // A live halting lane masks every younger lane of the same bundle
   always_comb begin
      live      = '0;
      ret_cnt   = '0;
      halt_live = 1'b0;
      for (int unsigned k = 0; k < NRET; k++) begin
         if (!flush_in && state == RUN && (valid_in[k] || trap_in[k]) && !halt_live) begin
            live[k] = 1'b1;
            if (valid_in[k] && !trap_in[k]) ret_cnt = ret_cnt + CW'(1);
            if (halt_in[k]) halt_live = 1'b1;
         end
      end
   end

   always_comb begin
      we_pre = '0;
      for (int unsigned k = 0; k < NRET; k++)
         we_pre[k] = live[k] && valid_in[k] && !trap_in[k] && rd_write_in[k] && (rd_in[k*5 +: 5] != '0);
   end

   always_comb begin
      rf_we_out = we_pre;
      for (int unsigned k = 0; k < NRET; k++)
         for (int unsigned j = k + 1; j < NRET; j++)
            if (we_pre[j] && rd_in[j*5 +: 5] == rd_in[k*5 +: 5]) rf_we_out[k] = 1'b0;
   end

   assign rf_waddr_out = rd_in;
   assign rf_wdata_out = rd_value_in;

   always_comb begin
      lanes = '0;
      for (int unsigned k = 0; k < NRET; k++) begin
         lanes[k].insn      = instr_in[k*XLEN +: XLEN];
         lanes[k].trap      = trap_in[k];
         lanes[k].halt      = halt_in[k];
         lanes[k].intr      = intr_in[k];
         lanes[k].mode      = RVFI_MODE_M;
         lanes[k].rs1_addr  = rs1_in[k*5 +: 5];
         lanes[k].rs2_addr  = rs2_in[k*5 +: 5];
         lanes[k].rs1_rdata = rs1_value_in[k*XLEN +: XLEN];
         lanes[k].rs2_rdata = rs2_value_in[k*XLEN +: XLEN];
         lanes[k].rd_addr   = rd_write_in[k] ? rd_in[k*5 +: 5] : 5'd0;
         lanes[k].rd_wdata  = (rd_write_in[k] && rd_in[k*5 +: 5] != '0) ? rd_value_in[k*XLEN +: XLEN] : '0;
         lanes[k].pc_rdata  = pc_in[k*XLEN +: XLEN];
         lanes[k].pc_wdata  = next_pc_in[k*XLEN +: XLEN];
         lanes[k].mem_addr  = mem_address_in[k*XLEN +: XLEN];
         lanes[k].mem_rmask = mem_read_mask_in[k*4 +: 4];
         lanes[k].mem_wmask = mem_write_mask_in[k*4 +: 4];
         lanes[k].mem_rdata = mem_read_value_in[k*XLEN +: XLEN];
         lanes[k].mem_wdata = mem_write_value_in[k*XLEN +: XLEN];
      end
   end

   rv32_wb_compact #(.NRET(NRET), .CW(CW)) u_compact (
      .live       (live),
      .lanes_in   (lanes),
      .order_base (order_base),
      .lanes_out  (packed_lanes),
      .count      (live_cnt)
   );

   always_comb begin
      state_next = state;
      if (state == RUN && halt_live) state_next = HALTED;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         order_base <= '0;
         instret    <= '0;
         rvfi_q     <= '0;
      end else begin
         state      <= state_next;
         order_base <= order_base + 64'(live_cnt);
         instret    <= instret + 64'(ret_cnt);
         // Unused slots keep their previous payload; only valid is dropped
         for (int unsigned j = 0; j < NRET; j++) begin
            if (j < 32'(live_cnt)) rvfi_q[j] <= packed_lanes[j];
            else                   rvfi_q[j].valid <= 1'b0;
         end
      end
   end

   assign instret_out = instret;
   assign halted_out  = (state == HALTED);

   always_comb begin
      rvfi_valid = '0; rvfi_order = '0; rvfi_insn = '0; rvfi_trap = '0; rvfi_halt = '0;
      rvfi_intr = '0; rvfi_mode = '0; rvfi_rs1_addr = '0; rvfi_rs2_addr = '0;
      rvfi_rs1_rdata = '0; rvfi_rs2_rdata = '0; rvfi_rd_addr = '0; rvfi_rd_wdata = '0;
      rvfi_pc_rdata = '0; rvfi_pc_wdata = '0; rvfi_mem_addr = '0; rvfi_mem_rmask = '0;
      rvfi_mem_wmask = '0; rvfi_mem_rdata = '0; rvfi_mem_wdata = '0;
      for (int unsigned j = 0; j < NRET; j++) begin
         rvfi_valid[j]            = rvfi_q[j].valid;
         rvfi_order[j*64 +: 64]   = rvfi_q[j].order;
         rvfi_insn[j*32 +: 32]    = rvfi_q[j].insn;
         rvfi_trap[j]             = rvfi_q[j].trap;
         rvfi_halt[j]             = rvfi_q[j].halt;
         rvfi_intr[j]             = rvfi_q[j].intr;
         rvfi_mode[j*2 +: 2]      = rvfi_q[j].mode;
         rvfi_rs1_addr[j*5 +: 5]  = rvfi_q[j].rs1_addr;
         rvfi_rs2_addr[j*5 +: 5]  = rvfi_q[j].rs2_addr;
         rvfi_rs1_rdata[j*32 +: 32] = rvfi_q[j].rs1_rdata;
         rvfi_rs2_rdata[j*32 +: 32] = rvfi_q[j].rs2_rdata;
         rvfi_rd_addr[j*5 +: 5]   = rvfi_q[j].rd_addr;
         rvfi_rd_wdata[j*32 +: 32] = rvfi_q[j].rd_wdata;
         rvfi_pc_rdata[j*32 +: 32] = rvfi_q[j].pc_rdata;
         rvfi_pc_wdata[j*32 +: 32] = rvfi_q[j].pc_wdata;
         rvfi_mem_addr[j*32 +: 32] = rvfi_q[j].mem_addr;
         rvfi_mem_rmask[j*4 +: 4] = rvfi_q[j].mem_rmask;
         rvfi_mem_wmask[j*4 +: 4] = rvfi_q[j].mem_wmask;
         rvfi_mem_rdata[j*32 +: 32] = rvfi_q[j].mem_rdata;
         rvfi_mem_wdata[j*32 +: 32] = rvfi_q[j].mem_wdata;
      end
   end

endmodule

// File: tb/tb_rv32_writeback_nret.sv
// Scoreboard bench for rv32_writeback_nret at NRET=2: RF writes checked same cycle, RVFI one cycle later.
module tb_rv32_writeback_nret;

   localparam int NRET = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              flush_in;
   logic [NRET-1:0]   valid_in, trap_in, halt_in, intr_in, rd_write_in;
   logic [NRET*5-1:0] rd_in, rs1_in, rs2_in;
   logic [NRET*32-1:0] rd_value_in, rs1_value_in, rs2_value_in, pc_in, next_pc_in, instr_in;
   logic [NRET*32-1:0] mem_address_in, mem_read_value_in, mem_write_value_in;
   logic [NRET*4-1:0] mem_read_mask_in, mem_write_mask_in;
   logic [NRET-1:0]   rf_we_out;
   logic [NRET*5-1:0] rf_waddr_out;
   logic [NRET*32-1:0] rf_wdata_out;
   logic [63:0]       instret_out;
   logic              halted_out;
   logic [NRET-1:0]   rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
   logic [NRET*64-1:0] rvfi_order;
   logic [NRET*2-1:0] rvfi_mode;
   logic [NRET*5-1:0] rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
   logic [NRET*32-1:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata;
   logic [NRET*32-1:0] rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
   logic [NRET*4-1:0] rvfi_mem_rmask, rvfi_mem_wmask;

   rv32_writeback_nret #(.NRET(NRET), .XLEN(32)) dut (
      .clk(clk), .reset(reset), .flush_in(flush_in), .valid_in(valid_in), .trap_in(trap_in),
      .halt_in(halt_in), .intr_in(intr_in), .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
      .rd_write_in(rd_write_in), .rd_value_in(rd_value_in), .rs1_value_in(rs1_value_in),
      .rs2_value_in(rs2_value_in), .pc_in(pc_in), .next_pc_in(next_pc_in), .instr_in(instr_in),
      .mem_address_in(mem_address_in), .mem_read_value_in(mem_read_value_in),
      .mem_write_value_in(mem_write_value_in), .mem_read_mask_in(mem_read_mask_in),
      .mem_write_mask_in(mem_write_mask_in), .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out),
      .rf_wdata_out(rf_wdata_out), .instret_out(instret_out), .halted_out(halted_out),
      .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
      .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode),
      .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
      .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
      .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
      .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
      .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata)
   );

   typedef struct {
      logic [1:0]        valid, halt, trap;
      logic [1:0][63:0]  order;
      logic [1:0][31:0]  pc, wd;
      logic [1:0][4:0]   rda;
      logic [63:0]       instret;
      logic              halted;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic [63:0] m_order, m_instret;
   logic        m_halted;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      flush_in = 1'b0; valid_in = '0; trap_in = '0; halt_in = '0; intr_in = '0; rd_write_in = '0;
      rd_in = '0; rs1_in = '0; rs2_in = '0; rd_value_in = '0; rs1_value_in = '0; rs2_value_in = '0;
      pc_in = '0; next_pc_in = '0; instr_in = '0; mem_address_in = '0; mem_read_value_in = '0;
      mem_write_value_in = '0; mem_read_mask_in = '0; mem_write_mask_in = '0;
   endtask

   task automatic set_lane(input int k, input bit v, input bit t, input bit h, input bit w,
                           input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc);
      valid_in[k] = v; trap_in[k] = t; halt_in[k] = h; rd_write_in[k] = w;
      rd_in[k*5 +: 5] = rd; rd_value_in[k*32 +: 32] = val;
      pc_in[k*32 +: 32] = pc; next_pc_in[k*32 +: 32] = pc + 32'd4;
      instr_in[k*32 +: 32] = 32'h0000_0013 | (32'(k) << 7);
   endtask

   // Inputs are already driven at a negedge; model the bundle, check RF now, RVFI after the edge.
   task automatic run_cycle(input string tag, input bit flush);
      logic [1:0] lv, wp, we;
      bit         hs;
      int         slot;
      exp_t       e, o;
      flush_in = flush;
      lv = '0; wp = '0; hs = 0; slot = 0;
      e.valid = '0; e.halt = '0; e.trap = '0; e.order = '0; e.pc = '0; e.wd = '0; e.rda = '0;
      for (int k = 0; k < 2; k++) begin
         if (!flush && !m_halted && (valid_in[k] || trap_in[k]) && !hs) lv[k] = 1'b1;
         if (lv[k] && halt_in[k]) hs = 1;
         wp[k] = lv[k] && valid_in[k] && !trap_in[k] && rd_write_in[k] && (rd_in[k*5 +: 5] != 5'd0);
      end
      we = wp;
      if (wp[1] && rd_in[9:5] == rd_in[4:0]) we[0] = 1'b0;
      #1;
      check({tag, ".rf_we"}, 64'(rf_we_out), 64'(we));
      for (int k = 0; k < 2; k++) if (we[k]) begin
         check({tag, ".rf_waddr"}, 64'(rf_waddr_out[k*5 +: 5]), 64'(rd_in[k*5 +: 5]));
         check({tag, ".rf_wdata"}, 64'(rf_wdata_out[k*32 +: 32]), 64'(rd_value_in[k*32 +: 32]));
      end
      for (int k = 0; k < 2; k++) if (lv[k]) begin
         e.valid[slot] = 1'b1;
         e.order[slot] = m_order + 64'(slot);
         e.pc[slot]    = pc_in[k*32 +: 32];
         e.wd[slot]    = (rd_write_in[k] && rd_in[k*5 +: 5] != 5'd0) ? rd_value_in[k*32 +: 32] : 32'd0;
         e.rda[slot]   = rd_write_in[k] ? rd_in[k*5 +: 5] : 5'd0;
         e.halt[slot]  = halt_in[k];
         e.trap[slot]  = trap_in[k];
         if (valid_in[k] && !trap_in[k]) m_instret = m_instret + 64'd1;
         slot++;
      end
      m_order = m_order + 64'(slot);
      if (hs) m_halted = 1'b1;
      e.instret = m_instret;
      e.halted  = m_halted;
      sb.push_back(e);
      @(posedge clk); #1;
      o = sb.pop_front();
      check({tag, ".rvfi_valid"}, 64'(rvfi_valid), 64'(o.valid));
      check({tag, ".instret"}, instret_out, o.instret);
      check({tag, ".halted"}, 64'(halted_out), 64'(o.halted));
      for (int j = 0; j < 2; j++) if (o.valid[j]) begin
         check({tag, ".order"}, rvfi_order[j*64 +: 64], o.order[j]);
         check({tag, ".pc"}, 64'(rvfi_pc_rdata[j*32 +: 32]), 64'(o.pc[j]));
         check({tag, ".pc_wdata"}, 64'(rvfi_pc_wdata[j*32 +: 32]), 64'(o.pc[j] + 32'd4));
         check({tag, ".rd_wdata"}, 64'(rvfi_rd_wdata[j*32 +: 32]), 64'(o.wd[j]));
         check({tag, ".rd_addr"}, 64'(rvfi_rd_addr[j*5 +: 5]), 64'(o.rda[j]));
         check({tag, ".halt"}, 64'(rvfi_halt[j]), 64'(o.halt[j]));
         check({tag, ".trap"}, 64'(rvfi_trap[j]), 64'(o.trap[j]));
         check({tag, ".mode"}, 64'(rvfi_mode[j*2 +: 2]), 64'd3);
      end
      @(negedge clk);
   endtask

   initial begin
      clear_inputs();
      reset = 1'b0;
      m_order = '0; m_instret = '0; m_halted = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset.rvfi_valid", 64'(rvfi_valid), 64'd0);
      check("reset.order0", rvfi_order[63:0], 64'd0);
      check("reset.instret", instret_out, 64'd0);
      check("reset.halted", 64'(halted_out), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      set_lane(0, 1, 0, 0, 1, 5'd5, 32'h1111, 32'h100);
      set_lane(1, 1, 0, 0, 1, 5'd6, 32'h2222, 32'h104);
      run_cycle("both_valid", 0);

      clear_inputs();
      set_lane(1, 1, 0, 0, 1, 5'd7, 32'h3333, 32'h104);
      run_cycle("lane1_only", 0);

      clear_inputs();
      set_lane(0, 1, 0, 0, 1, 5'd3, 32'hAAAA, 32'h200);
      set_lane(1, 1, 0, 0, 1, 5'd3, 32'hBBBB, 32'h204);
      run_cycle("waw_rd3", 0);

      clear_inputs();
      set_lane(0, 1, 0, 0, 1, 5'd7, 32'h7777, 32'h300);
      set_lane(1, 1, 1, 0, 1, 5'd8, 32'h8888, 32'h304);
      run_cycle("trap_lane1", 0);

      clear_inputs();
      set_lane(0, 1, 0, 1, 1, 5'd9, 32'h9999, 32'h400);
      set_lane(1, 1, 0, 0, 1, 5'd10, 32'hA0A0, 32'h404);
      run_cycle("flush_halt", 1);

      clear_inputs();
      run_cycle("idle", 0);

      set_lane(0, 1, 0, 0, 1, 5'd0, 32'hDEAD, 32'h500);
      set_lane(1, 1, 0, 0, 0, 5'd4, 32'hBEEF, 32'h504);
      run_cycle("rd_zero", 0);

      for (int i = 0; i < 12; i++) begin
         clear_inputs();
         for (int k = 0; k < 2; k++)
            set_lane(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 0,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom, 32'h1000 + 32'(i*8 + k*4));
         run_cycle("random", $urandom_range(0, 4) == 0);
      end

      clear_inputs();
      set_lane(0, 1, 0, 0, 1, 5'd11, 32'h1234, 32'h600);
      set_lane(1, 1, 0, 0, 1, 5'd12, 32'h5678, 32'h604);
      #2 reset = 1'b0;
      #1;
      check("midreset.rvfi_valid", 64'(rvfi_valid), 64'd0);
      check("midreset.instret", instret_out, 64'd0);
      check("midreset.order0", rvfi_order[63:0], 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      m_order = '0; m_instret = '0; m_halted = 1'b0;
      sb.delete();
      run_cycle("after_reset", 0);

      clear_inputs();
      set_lane(0, 1, 0, 1, 1, 5'd13, 32'hCAFE, 32'h700);
      set_lane(1, 1, 0, 0, 1, 5'd14, 32'hF00D, 32'h704);
      run_cycle("halt_lane0", 0);

      clear_inputs();
      set_lane(0, 1, 0, 0, 1, 5'd15, 32'h0F0F, 32'h800);
      set_lane(1, 1, 0, 0, 1, 5'd16, 32'hF0F0, 32'h804);
      run_cycle("post_halt", 0);
      run_cycle("post_halt2", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
